uart_mem_master: RTL

UART_MEM_MASTER -- requirements
Module: uart_mem_master

---
 rtl/uart_mem_master.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_master.sv
// UART-driven memory bus master: 'W'/'R' word access, 'G' releases cpu_hold.
// Replies go back over the same UART; a stuck bus access is aborted after TIMEOUT cycles.
module uart_mem_master #(
    parameter int unsigned TIMEOUT       = 65535,
    parameter logic        HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_read,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        tx_write,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        cpu_hold
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_Q = 8'h3F;
    localparam logic [7:0] RSP_E = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_MEM,
        S_SEND
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_sr_q, addr_sr_d;
    logic [31:0] data_sr_q, data_sr_d;
    logic [31:0] send_buf_q, send_buf_d;
    logic [2:0]  send_cnt_q, send_cnt_d;
    logic        rx_read_q, rx_read_d;
    logic        rx_skip_q, rx_skip_d;
    logic        tx_write_q, tx_write_d;
    logic        tx_skip_q, tx_skip_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        rx_ok;
    logic        tx_ok;

    assign rx_read   = rx_read_q;
    assign tx_write  = tx_write_q;
    assign tx_data   = tx_data_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign cpu_hold  = cpu_hold_q;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            cnt_q       <= 2'd0;
            addr_sr_q   <= 32'h0;
            data_sr_q   <= 32'h0;
            send_buf_q  <= 32'h0;
            send_cnt_q  <= 3'd0;
            rx_read_q   <= 1'b0;
            rx_skip_q   <= 1'b0;
            tx_write_q  <= 1'b0;
            tx_skip_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            tmo_q       <= '0;
            cpu_hold_q  <= HOLD_AT_RESET;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            addr_sr_q   <= addr_sr_d;
            data_sr_q   <= data_sr_d;
            send_buf_q  <= send_buf_d;
            send_cnt_q  <= send_cnt_d;
            rx_read_q   <= rx_read_d;
            rx_skip_q   <= rx_skip_d;
            tx_write_q  <= tx_write_d;
            tx_skip_q   <= tx_skip_d;
            tx_data_q   <= tx_data_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            tmo_q       <= tmo_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    // Strobes are staggered: a new strobe waits until the previous one has cleared
    assign rx_ok = rx_ready && !rx_read_q && !rx_skip_q;
    assign tx_ok = tx_ready && !tx_write_q && !tx_skip_q && !rx_read_q;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        addr_sr_d   = addr_sr_q;
        data_sr_d   = data_sr_q;
        send_buf_d  = send_buf_q;
        send_cnt_d  = send_cnt_q;
        rx_read_d   = 1'b0;
        rx_skip_d   = rx_read_q;
        tx_write_d  = 1'b0;
        tx_skip_d   = tx_write_q;
        tx_data_d   = tx_data_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        tmo_d       = tmo_q;
        cpu_hold_d  = cpu_hold_q;

        case (state_q)
            S_IDLE: begin
                if (rx_ok) begin
                    rx_read_d = 1'b1;
                    cmd_d     = rx_data;
                    cnt_d     = 2'd0;
                    case (rx_data)
                        CMD_W, CMD_R: state_d = S_ADDR;
                        CMD_G: begin
                            cpu_hold_d = 1'b0;
                            send_buf_d = {RSP_K, 24'h0};
                            send_cnt_d = 3'd1;
                            state_d    = S_SEND;
                        end
                        default: begin
                            send_buf_d = {RSP_Q, 24'h0};
                            send_cnt_d = 3'd1;
                            state_d    = S_SEND;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_ok) begin
                    rx_read_d = 1'b1;
                    addr_sr_d = {addr_sr_q[23:0], rx_data};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = (cmd_q == CMD_W) ? S_DATA : S_MEM;
                    end
                end
            end
            S_DATA: begin
                if (rx_ok) begin
                    rx_read_d = 1'b1;
                    data_sr_d = {data_sr_q[23:0], rx_data};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_MEM;
                    end
                end
            end
            S_MEM: begin
                if (!mem_valid_q) begin
                    if (!rx_read_q) begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {addr_sr_q[31:2], 2'b00};
                        mem_wdata_d = (cmd_q == CMD_W) ? data_sr_q : 32'h0;
                        mem_wstrb_d = (cmd_q == CMD_W) ? 4'b1111 : 4'b0000;
                        tmo_d       = '0;
                    end
                end else if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    state_d     = S_SEND;
                    if (cmd_q == CMD_R) begin
                        send_buf_d = mem_rdata;
                        send_cnt_d = 3'd4;
                    end else begin
                        send_buf_d = {RSP_K, 24'h0};
                        send_cnt_d = 3'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    send_buf_d  = {RSP_E, 24'h0};
                    send_cnt_d  = 3'd1;
                    state_d     = S_SEND;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_SEND: begin
                if (tx_ok) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = send_buf_q[31:24];
                    send_buf_d = {send_buf_q[23:0], 8'h00};
                    send_cnt_d = send_cnt_q - 3'd1;
                    if (send_cnt_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
